// File: rtl/frame_buffer_ram.sv
// frame_buffer_ram
// Dual-port pixel frame buffer. Port A is the draw-side write port. Port B is
// the scan-side read port with a selectable read latency. A built-in clear
// engine fills the whole memory with one value without external address sweeps.
module frame_buffer_ram #(
  parameter int DATA_W   = 7,
  parameter int ADDR_W   = 12,
  parameter int DEPTH    = 4096,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] din_a,
  output logic              a_ready,
  input  logic              re_b,
  input  logic [ADDR_W-1:0] addr_b,
  output logic [DATA_W-1:0] dout_b,
  output logic              dout_b_valid,
  input  logic              clear_req,
  input  logic [DATA_W-1:0] clear_val,
  output logic              busy,
  output logic              clear_done
);

  // Addresses are widened by one bit, so DEPTH == 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH-1);

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

  logic [DATA_W-1:0] mem [DEPTH];

  state_t            r_state;
  logic [ADDR_W-1:0] r_count;
  logic [DATA_W-1:0] r_fillVal;
  logic              r_busy;
  logic              r_clearDone;
  logic [DATA_W-1:0] r_dout;
  logic              r_valid;

  logic              w_addrAInRange;
  logic              w_addrBInRange;
  logic              w_writeA;
  logic              w_fillWrite;
  logic [DATA_W-1:0] w_rdData;

  assign w_addrAInRange = ({1'b0, addr_a} < DEPTH_EXT);
  assign w_addrBInRange = ({1'b0, addr_b} < DEPTH_EXT);
  assign w_writeA       = we && !r_busy && w_addrAInRange;
  assign w_fillWrite    = (r_state == FILL);
  assign w_rdData       = w_addrBInRange ? mem[addr_b] : '0;

  assign a_ready      = !r_busy;
  assign busy         = r_busy;
  assign clear_done   = r_clearDone;
  assign dout_b       = r_dout;
  assign dout_b_valid = r_valid;

  // Clear engine: latch the fill value, sweep every address once, then pulse done.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_count     <= '0;
      r_fillVal   <= '0;
      r_busy      <= 1'b0;
      r_clearDone <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_clearDone <= 1'b0;
          if (clear_req) begin
            r_fillVal <= clear_val;
            r_count   <= '0;
            r_busy    <= 1'b1;
            r_state   <= FILL;
          end
        end
        FILL: begin
          if (r_count == LAST_ADDR) begin
            r_busy      <= 1'b0;
            r_clearDone <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_count <= r_count + 1'b1;
          end
        end
        DONE: begin
          r_clearDone <= 1'b0;
          r_state     <= IDLE;
        end
        default: begin
          r_busy      <= 1'b0;
          r_clearDone <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  // Memory write port: fill engine while clearing, otherwise port A; nothing lands during reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (w_fillWrite) begin
        mem[r_count] <= r_fillVal;
      end else if (w_writeA) begin
        mem[addr_a] <= din_a;
      end
    end
  end

  generate
    if (READ_LAT == 2) begin : g_lat2
      logic [DATA_W-1:0] r_stageData;
      logic              r_stageValid;

      // First read stage: array lookup, read-first against a same-edge write.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_stageData  <= '0;
          r_stageValid <= 1'b0;
        end else begin
          r_stageValid <= re_b;
          if (re_b) begin
            r_stageData <= w_rdData;
          end
        end
      end

      // Output register: only issued reads update the visible data, which otherwise holds.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_dout  <= '0;
          r_valid <= 1'b0;
        end else begin
          r_valid <= r_stageValid;
          if (r_stageValid) begin
            r_dout <= r_stageData;
          end
        end
      end
    end else begin : g_lat1
      // Single-stage read: array lookup straight into the output register.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_dout  <= '0;
          r_valid <= 1'b0;
        end else begin
          r_valid <= re_b;
          if (re_b) begin
            r_dout <= w_rdData;
          end
        end
      end
    end
  endgenerate

endmodule

// File: doc/frame_buffer_ram.md
Name: frame_buffer_ram

Overview:
- Parametrised dual-port pixel frame buffer between the cursor/draw logic (write port A) and the VGA scan logic (read port B).
- Generalises the fixed 4096x7 dual-port RAM with configurable geometry and a selectable read latency.
- Adds a read-valid strobe and a hardware clear (fill) engine, so the "shake to erase" action wipes the canvas without CPU/FSM address sweeping.

Parameters:
- DATA_W, 7, pixel word width in bits.
- ADDR_W, 12, address width for both ports.
- DEPTH, 4096, number of words; must satisfy 2 <= DEPTH <= 2**ADDR_W.
- READ_LAT, 1, read latency in cycles; legal values are 1 and 2 only (2 adds an output register).

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- we  input  1  port A write enable.
- addr_a  input  ADDR_W  port A write address.
- din_a  input  DATA_W  port A write data.
- a_ready  output  1  high when port A writes are accepted; equals !busy.
- re_b  input  1  port B read enable.
- addr_b  input  ADDR_W  port B read address.
- dout_b  output  DATA_W  port B read data.
- dout_b_valid  output  1  high in the cycle dout_b holds the data for an issued read.
- clear_req  input  1  single-cycle request to fill the whole memory.
- clear_val  input  DATA_W  fill value; sampled in the cycle clear_req is accepted.
- busy  output  1  clear engine active.
- clear_done  output  1  one-cycle pulse after the last fill write.

Behaviour:
- Reset (rst high at a clock edge):
  - dout_b=0, dout_b_valid=0, busy=0, clear_done=0, so a_ready=1.
  - FSM goes to IDLE, fill counter=0, read pipeline flushed.
  - Memory contents are not modified; writes and reads presented during rst are ignored.
- Port A write:
  - Commits mem[addr_a]<=din_a at the edge where we=1, a_ready=1, rst=0 and addr_a<DEPTH.
  - Otherwise the write is dropped; there is no queueing or back-pressure beyond a_ready.
- Port B read:
  - re_b=1 at edge N gives dout_b=mem[addr_b] and dout_b_valid=1 after edge N+READ_LAT-1, i.e. visible in cycle N+READ_LAT.
  - dout_b holds its last value when no read is issued; dout_b_valid is high only for issued reads.
  - addr_b>=DEPTH returns 0 with dout_b_valid=1.
  - Back-to-back reads give one result per cycle.
- Collision: a read and a write to the same address on the same edge are read-first; the read returns the old data.
- Clear FSM states IDLE, FILL, DONE:
  - IDLE -> FILL when clear_req=1: latches clear_val, counter=0, busy=1 from the next cycle.
  - FILL: writes mem[counter]<=fill_val each cycle, then counter+1. After writing DEPTH-1 -> DONE. Occupies exactly DEPTH cycles.
  - DONE: clear_done=1 for one cycle, busy=0 -> IDLE.
  - Total clear_req to clear_done is DEPTH+1 edges.
  - clear_req in FILL or DONE is ignored; there is no retrigger or queueing.
  - A port A write in the same cycle clear_req is accepted in IDLE commits, then is overwritten by the fill.
  - Port A writes during FILL and DONE are dropped (a_ready=0).
  - Port B reads stay fully functional during FILL; they return the filled value for counter addresses already passed and old data otherwise.
  - Reset mid-FILL aborts immediately: the partially filled memory is kept, no clear_done pulse, FSM goes to IDLE.
  - Counter width is ADDR_W; it never wraps because the FSM exits at DEPTH-1.

Test Plan:
- Defaults, READ_LAT=1: write addr 1..7 with data 1..7, then read 1..5 back-to-back -> dout_b=1,2,3,4,5 one cycle after each issue, dout_b_valid continuously high for 5 cycles.
- READ_LAT=2: read addr 3 after writing 7'h3 -> dout_b=3 and valid exactly 2 cycles after re_b; valid low in the intermediate cycle.
- Same-edge collision: mem[9]=7'h11, we=1 din_a=7'h22 addr_a=9, re_b=1 addr_b=9 -> dout_b=7'h11; the next read of 9 gives 7'h22.
- DEPTH=16, ADDR_W=4:
  - Step 1: pre-write distinct values, pulse clear_req with clear_val=7'h7F.
  - Step 2: check busy=1 for 16 cycles, a_ready=0, and a write of 7'h05 to addr 3 mid-fill is dropped.
  - Step 3: check clear_done pulses once at edge 17.
  - Step 4: read all 16 addresses -> 7'h7F.
- DEPTH=16: clear_req with 7'h2A, assert rst after 5 fill cycles -> busy=0 and no clear_done; addr 0-4 read 7'h2A and addr 5-15 keep their old values.
- Second clear_req while busy -> ignored: single clear_done pulse, and the fill value stays the first latched clear_val.
